// File: rtl/spi_burst_ctrl_if.sv
// spi_burst_ctrl_if: master-side FIFO bundle of the SPI burst controller.
// TX push, RX pop and per-byte completion from the SPI master.
interface spi_burst_ctrl_if;
  logic       m_wr_en;
  logic [7:0] m_wr_data;
  logic       m_full;
  logic       m_rd_en;
  logic [7:0] m_rd_data;
  logic       m_empty;
  logic       m_done;

  modport master (
    output m_wr_en, m_wr_data, m_rd_en,
    input  m_full, m_rd_data, m_empty, m_done
  );

  modport slave (
    input  m_wr_en, m_wr_data, m_rd_en,
    output m_full, m_rd_data, m_empty, m_done
  );
endinterface

// File: rtl/spi_burst_ctrl.sv
// spi_burst_ctrl: pushes a TX buffer burst into an SPI master,
// waits for per-byte completion, then drains RX into a host buffer.
module spi_burst_ctrl #(
  parameter int TIMEOUT = 65535,
  parameter int MAX_LEN = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] len,
  input  logic       buf_wr_en,
  input  logic [3:0] buf_addr,
  input  logic [7:0] buf_wr_data,
  input  logic [3:0] rx_addr,
  output logic [7:0] rx_rdata,
  output logic       busy,
  output logic       xfer_done,
  output logic       err,
  spi_burst_ctrl_if.master m
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, WAIT, DRAIN, FIN
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [4:0]      len_q;
  logic [4:0]      push_idx;
  logic [4:0]      done_cnt;
  logic [4:0]      pop_idx;
  logic            rd_pend;
  logic [TW-1:0]   tcnt;
  logic            err_q;

  logic [7:0] tx_mem [MAX_LEN];
  logic [7:0] rx_mem [MAX_LEN];

  logic len_ok;
  logic active;
  logic to_hit;
  logic last_push;
  logic last_pop;

  assign len_ok    = (len != 5'd0) && (len <= 5'(MAX_LEN));
  assign active    = (state_q == LOAD) || (state_q == WAIT);
  // tcnt holds idle cycles minus one, so this fires on the
  // TIMEOUT-th cycle without a byte completion
  assign to_hit    = active && !m.m_done &&
                     (tcnt == TW'(TIMEOUT - 1));
  assign last_push = push_idx == (len_q - 5'd1);
  assign last_pop  = pop_idx == (len_q - 5'd1);

  assign rx_rdata  = rx_mem[rx_addr];
  assign err       = err_q;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state and handshake outputs
  always_comb begin
    state_d     = state_q;
    busy        = 1'b0;
    xfer_done   = 1'b0;
    m.m_wr_en   = 1'b0;
    m.m_wr_data = 8'h00;
    m.m_rd_en   = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (start && len_ok) state_d = LOAD;
        end
        LOAD: begin
          busy = 1'b1;
          if (to_hit) begin
            xfer_done = 1'b1;
            state_d   = IDLE;
          end else if (!m.m_full) begin
            m.m_wr_en   = 1'b1;
            m.m_wr_data = tx_mem[push_idx[3:0]];
            if (last_push) state_d = WAIT;
          end
        end
        WAIT: begin
          busy = 1'b1;
          if (to_hit) begin
            xfer_done = 1'b1;
            state_d   = IDLE;
          end else if (done_cnt == len_q) begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          busy      = 1'b1;
          m.m_rd_en = !m.m_empty && !rd_pend;
          if (rd_pend && last_pop) state_d = FIN;
        end
        FIN: begin
          busy      = 1'b1;
          xfer_done = 1'b1;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // counters, indices and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      push_idx <= '0;
      done_cnt <= '0;
      pop_idx  <= '0;
      rd_pend  <= 1'b0;
      tcnt     <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        if (len_ok) begin
          len_q    <= len;
          err_q    <= 1'b0;
          push_idx <= '0;
          done_cnt <= '0;
          pop_idx  <= '0;
          rd_pend  <= 1'b0;
          tcnt     <= '0;
        end else begin
          err_q <= 1'b1;
        end
      end
      if (m.m_wr_en) push_idx <= push_idx + 5'd1;
      if (active) begin
        if (m.m_done) begin
          done_cnt <= done_cnt + 5'd1;
          tcnt     <= '0;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
        if (to_hit) err_q <= 1'b1;
      end
      if (state_q == DRAIN) begin
        rd_pend <= m.m_rd_en;
        if (rd_pend) pop_idx <= pop_idx + 5'd1;
      end
    end
  end

  // buffers: host writes only while idle, RX capture one cycle after pop
  always_ff @(posedge clk) begin
    if (!rst && state_q == IDLE && buf_wr_en)
      tx_mem[buf_addr] <= buf_wr_data;
    if (!rst && state_q == DRAIN && rd_pend)
      rx_mem[pop_idx[3:0]] <= m.m_rd_data;
  end

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// tb_spi_burst_ctrl: loopback SPI master model plus burst-level
// reference (pushed bytes and RX contents equal the TX buffer).
module tb_spi_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [4:0] len = '0;
  logic       buf_wr_en = 1'b0;
  logic [3:0] buf_addr = '0;
  logic [7:0] buf_wr_data = '0;
  logic [3:0] rx_addr = '0;
  logic [7:0] rx_rdata;
  logic       busy;
  logic       xfer_done;
  logic       err;

  spi_burst_ctrl_if mi ();

  spi_burst_ctrl #(.TIMEOUT(100), .MAX_LEN(16)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .len(len),
    .buf_wr_en(buf_wr_en),
    .buf_addr(buf_addr),
    .buf_wr_data(buf_wr_data),
    .rx_addr(rx_addr),
    .rx_rdata(rx_rdata),
    .busy(busy),
    .xfer_done(xfer_done),
    .err(err),
    .m(mi)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_ref [16];
  logic [7:0] txq [$];
  logic [7:0] rxq [$];
  logic [7:0] push_log [$];
  int         push_cyc [$];
  int  cyc = 0;
  int  xdone_cnt, xdone_cyc, last_done_cyc, start_cyc;
  int  fin_cnt, hold_after, full_cyc, viol, stall_left, push_cnt;
  int  rd_seen, left;
  bit  withhold = 0, stall_en = 0, mbusy = 0;
  logic [7:0] cur;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // loopback SPI master: TX FIFO -> byte timer -> m_done + RX FIFO
  always @(posedge clk) begin
    if (rst) begin
      txq.delete();
      rxq.delete();
      mbusy = 0;
      stall_left = 0;
      mi.m_done    <= 1'b0;
      mi.m_full    <= 1'b0;
      mi.m_empty   <= 1'b1;
      mi.m_rd_data <= 8'h00;
    end else begin
      if (start && !busy) start_cyc = cyc;
      if (xfer_done) begin
        xdone_cnt++;
        xdone_cyc = cyc;
      end
      if (mi.m_done) last_done_cyc = cyc;
      if (mi.m_full) full_cyc++;
      if (mi.m_wr_en && mi.m_full) viol++;
      if (mi.m_rd_en) rd_seen = 1;
      mi.m_done <= 1'b0;
      if (mbusy) begin
        left--;
        if (left == 0) begin
          mi.m_done <= 1'b1;
          rxq.push_back(cur);
          mbusy = 0;
          fin_cnt++;
        end
      end else if (txq.size() > 0 &&
                   !(withhold && fin_cnt >= hold_after)) begin
        cur = txq.pop_front();
        mbusy = 1;
        left = $urandom_range(1, 4);
      end
      if (mi.m_wr_en) begin
        txq.push_back(mi.m_wr_data);
        push_log.push_back(mi.m_wr_data);
        push_cyc.push_back(cyc);
        push_cnt++;
      end
      if (stall_left > 0) stall_left--;
      if (mi.m_wr_en && stall_en && push_cnt == 3) stall_left = 5;
      if (mi.m_rd_en) begin
        if (rxq.size() > 0) mi.m_rd_data <= rxq.pop_front();
        else viol++;
      end
      mi.m_empty <= (rxq.size() == 0);
      mi.m_full  <= (stall_left > 0);
    end
    cyc++;
  end

  task automatic clear();
    push_log.delete();
    push_cyc.delete();
    xdone_cnt = 0;
    fin_cnt = 0;
    full_cyc = 0;
    viol = 0;
    push_cnt = 0;
    rd_seen = 0;
    start_cyc = -100;
    last_done_cyc = 0;
    xdone_cyc = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      buf_wr_en = 1'b1;
      buf_addr = 4'(i);
      buf_wr_data = 8'($urandom);
      tx_ref[i] = buf_wr_data;
    end
    @(negedge clk);
    buf_wr_en = 1'b0;
  endtask

  task automatic run_burst(input int n);
    clear();
    @(negedge clk);
    start = 1'b1;
    len = 5'(n);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3000 && xdone_cnt == 0; i++) @(negedge clk);
    chk("xfer_done seen", 32'(xdone_cnt > 0), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic verify(input int n, input string tag);
    chk({tag, " npush"}, push_log.size(), n);
    if (push_cyc.size() > 0)
      chk({tag, " latency"}, push_cyc[0] - start_cyc, 1);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s push%0d", tag, i),
          (i < push_log.size()) ? push_log[i] : 8'hxx, tx_ref[i]);
    for (int i = 0; i < n; i++) begin
      rx_addr = 4'(i);
      #1;
      chk($sformatf("%s rx%0d", tag, i), rx_rdata, tx_ref[i]);
    end
    chk({tag, " ndone"}, xdone_cnt, 1);
    chk({tag, " err"}, err, 0);
    chk({tag, " busy"}, busy, 0);
  endtask

  task automatic bad_start(input int n, input string tag);
    int seen;
    clear();
    seen = 0;
    @(negedge clk);
    start = 1'b1;
    len = 5'(n);
    @(negedge clk);
    start = 1'b0;
    chk({tag, " err"}, err, 1);
    repeat (4) begin
      seen |= int'(busy);
      @(negedge clk);
    end
    chk({tag, " busy"}, seen, 0);
    chk({tag, " npush"}, push_log.size(), 0);
    chk({tag, " ndone"}, xdone_cnt, 0);
  endtask

  initial begin
    int n;
    clear();
    repeat (2) @(negedge clk);
    chk("in reset", {busy, xfer_done, err, mi.m_wr_en,
                     mi.m_rd_en, mi.m_wr_data}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("after reset", {busy, xfer_done, err, mi.m_wr_en,
                        mi.m_rd_en, mi.m_wr_data}, 0);

    // two-byte loopback
    fill_rand();
    @(negedge clk);
    buf_wr_en = 1'b1;
    buf_addr = 4'd0;
    buf_wr_data = 8'hA5;
    @(negedge clk);
    buf_addr = 4'd1;
    buf_wr_data = 8'h3C;
    @(negedge clk);
    buf_wr_en = 1'b0;
    tx_ref[0] = 8'hA5;
    tx_ref[1] = 8'h3C;
    run_burst(2);
    verify(2, "two");
    if (push_cyc.size() == 2)
      chk("two back2back", push_cyc[1] - push_cyc[0], 1);

    // full stall after the 3rd push
    fill_rand();
    stall_en = 1;
    run_burst(16);
    stall_en = 0;
    verify(16, "stall");
    chk("stall full cycles", full_cyc, 5);
    chk("stall push while full", viol, 0);

    // illegal lengths
    bad_start(0, "len0");
    do_reset();
    bad_start(17, "len17");

    // timeout: master stops after the first byte
    do_reset();
    fill_rand();
    withhold = 1;
    hold_after = 1;
    run_burst(4);
    chk("to ndone", xdone_cnt, 1);
    chk("to gap", xdone_cyc - last_done_cyc, 100);
    chk("to err", err, 1);
    chk("to busy", busy, 0);
    chk("to npush", push_log.size(), 4);
    withhold = 0;
    do_reset();

    // second start and host write while busy
    fill_rand();
    fork
      run_burst(8);
      begin
        repeat (3) @(negedge clk);
        start = 1'b1;
        len = 5'd3;
        buf_wr_en = 1'b1;
        buf_addr = 4'd7;
        buf_wr_data = ~tx_ref[7];
        @(negedge clk);
        start = 1'b0;
        buf_wr_en = 1'b0;
      end
    join
    verify(8, "mid");
    run_burst(8);
    verify(8, "mid again");

    // reset during drain
    fill_rand();
    clear();
    @(negedge clk);
    start = 1'b1;
    len = 5'd4;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 500 && rd_seen == 0; i++) @(negedge clk);
    chk("drain reached", rd_seen, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("drain rst out", {busy, xfer_done, err, mi.m_wr_en,
                          mi.m_rd_en, mi.m_wr_data}, 0);
    rst = 1'b0;
    clear();
    repeat (5) @(negedge clk);
    chk("post rst quiet", push_log.size() + rd_seen, 0);
    chk("post rst busy", busy, 0);
    run_burst(1);
    verify(1, "one");

    // randomized bursts
    for (int k = 0; k < 6; k++) begin
      fill_rand();
      n = $urandom_range(1, 16);
      run_burst(n);
      verify(n, $sformatf("rnd%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
